// File: rtl/universal_reg_pkg.sv
// Shared op encoding and FSM state type for the universal shift register.
package universal_reg_pkg;

  localparam int unsigned OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_HOLD  = 3'd0;
  localparam op_t OP_LOAD  = 3'd1;
  localparam op_t OP_CLEAR = 3'd2;
  localparam op_t OP_SHL   = 3'd3;
  localparam op_t OP_SHR   = 3'd4;
  localparam op_t OP_ASR   = 3'd5;
  localparam op_t OP_ROL   = 3'd6;
  localparam op_t OP_ROR   = 3'd7;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/universal_reg_shift1_unit.sv
// Purely combinational single-position shift/rotate step and departing bit.
module shift1_unit
  import universal_reg_pkg::*;
#(
  parameter int unsigned NBITS = 16
) (
  input  logic [NBITS-1:0] d,
  input  op_t              op,
  input  logic             serial_in,
  output logic [NBITS-1:0] next_d,
  output logic             out_bit
);

  // One step of the selected shift; non-shift ops pass the value through.
  always_comb begin
    next_d  = d;
    out_bit = 1'b0;
    case (op)
      OP_SHL: begin
        next_d  = {d[NBITS-2:0], serial_in};
        out_bit = d[NBITS-1];
      end
      OP_SHR: begin
        next_d  = {serial_in, d[NBITS-1:1]};
        out_bit = d[0];
      end
      OP_ASR: begin
        next_d  = {d[NBITS-1], d[NBITS-1:1]};
        out_bit = d[0];
      end
      OP_ROL: begin
        next_d  = {d[NBITS-2:0], d[NBITS-1]};
        out_bit = d[NBITS-1];
      end
      OP_ROR: begin
        next_d  = {d[0], d[NBITS-1:1]};
        out_bit = d[0];
      end
      default: begin
        next_d  = d;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/universal_reg.sv
// Universal register: load/clear/hold in one cycle, multi-cycle shifts one bit per clock.
module universal_reg
  import universal_reg_pkg::*;
#(
  parameter int unsigned        NBITS       = 16,
  parameter logic [NBITS-1:0]   RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [2:0]                 op,
  input  logic [$clog2(NBITS)-1:0]   amt,
  input  logic [NBITS-1:0]           data,
  input  logic                       serial_in,
  output logic [NBITS-1:0]           dataReg,
  output logic                       busy,
  output logic                       done,
  output logic                       serial_out
);

  localparam int unsigned AW = $clog2(NBITS);

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  op_t             op_q, op_d;
  logic [NBITS-1:0] data_d;
  logic            sout_d;
  logic            done_d;
  logic [NBITS-1:0] step_d;
  logic            step_bit;

  // Shift datapath always operates on the latched op, so op changes mid-shift are harmless.
  shift1_unit #(
    .NBITS(NBITS)
  ) u_shift1 (
    .d        (dataReg),
    .op       (op_q),
    .serial_in(serial_in),
    .next_d   (step_d),
    .out_bit  (step_bit)
  );

  assign busy = (state_q == SHIFT);

  // Next-state and next-output logic; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    data_d  = dataReg;
    sout_d  = serial_out;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_HOLD: begin
              done_d = 1'b1;
            end
            OP_LOAD: begin
              data_d = data;
              done_d = 1'b1;
            end
            OP_CLEAR: begin
              data_d = '0;
              done_d = 1'b1;
            end
            default: begin
              if (amt == '0) begin
                done_d = 1'b1;
              end else begin
                op_d    = op;
                cnt_d   = amt;
                state_d = SHIFT;
              end
            end
          endcase
        end
      end
      SHIFT: begin
        data_d = step_d;
        sout_d = step_bit;
        cnt_d  = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // All state, including outputs, is held here with async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= OP_HOLD;
      dataReg    <= RESET_VALUE;
      serial_out <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      dataReg    <= data_d;
      serial_out <= sout_d;
      done       <= done_d;
    end
  end

endmodule

// File: doc/universal_reg.md
UNIVERSAL_REG -- requirements
Module: universal_reg

Interface
REQ-001 Parameter: NBITS, default 16, register width; legal range 2..64.
REQ-002 Parameter: RESET_VALUE, default 0, NBITS-wide value loaded into dataReg on reset.
REQ-003 Localparam: AW = $clog2(NBITS), width of the shift-amount field.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  command strobe; sampled only in IDLE.
REQ-007 op  input  3  command: 0 HOLD, 1 LOAD, 2 CLEAR, 3 SHL, 4 SHR, 5 ASR, 6 ROL, 7 ROR.
REQ-008 amt  input  AW  shift count for ops 3..7; range 0..NBITS-1.
REQ-009 data  input  NBITS  parallel load value.
REQ-010 serial_in  input  1  fill bit for SHL (into LSB) and SHR (into MSB).
REQ-011 dataReg  output  NBITS  registered contents.
REQ-012 busy  output  1  high while a multi-cycle shift is in progress.
REQ-013 done  output  1  one-cycle pulse marking command completion.
REQ-014 serial_out  output  1  registered copy of the bit most recently shifted or rotated out.

Function
REQ-015 The FSM SHALL have two states, IDLE and SHIFT; busy SHALL equal (state == SHIFT).
REQ-016 In IDLE, start=0 SHALL leave every output unchanged, and done SHALL be 0.
REQ-017 In IDLE with start=1, HOLD SHALL leave dataReg unchanged and SHALL pulse done in the next cycle.
REQ-018 In IDLE with start=1, LOAD SHALL write data to dataReg at that edge and SHALL pulse done in the next cycle.
REQ-019 In IDLE with start=1, CLEAR SHALL write all zeros to dataReg at that edge and SHALL pulse done in the next cycle.
REQ-020 In IDLE with start=1, a shift op with amt=0 SHALL leave dataReg and serial_out unchanged and SHALL pulse done in the next cycle.
REQ-021 In IDLE with start=1, a shift op with amt>0 SHALL latch op and amt into an internal counter and SHALL go to SHIFT without modifying dataReg.
REQ-022 In SHIFT, each edge SHALL perform exactly one single-position shift and decrement the counter; on the edge where the counter reaches 0, the FSM SHALL return to IDLE and done SHALL go high for one cycle.
REQ-023 busy SHALL therefore be high for exactly amt cycles, and the final value SHALL be visible together with done.
REQ-024 Single-step semantics SHALL be:
  - SHL: {d[N-2:0], serial_in}.
  - SHR: {serial_in, d[N-1:1]}.
  - ASR: {d[N-1], d[N-1:1]}.
  - ROL: {d[N-2:0], d[N-1]}.
  - ROR: {d[0], d[N-1:1]}.
REQ-025 On each step, serial_out SHALL take the departing bit: d[N-1] for SHL and ROL, d[0] for SHR, ASR and ROR.
REQ-026 serial_in SHALL be sampled on every step edge, not only at start.
REQ-027 start (and every op including CLEAR) SHALL be ignored while busy; data, op and amt changes during SHIFT SHALL have no effect.
REQ-028 done SHALL never be high in two consecutive cycles unless two commands complete back-to-back.
REQ-029 A new start MAY be accepted in the same cycle done is high, since the FSM is in IDLE.

Reset
REQ-030 rst=0 SHALL asynchronously force dataReg=RESET_VALUE, serial_out=0, busy=0, done=0, state=IDLE and counter=0.
REQ-031 Reset asserted mid-shift SHALL abort the command without a done pulse.
REQ-032 After rst deasserts, the first accepted start SHALL be the first rising edge with start=1.

Structure
REQ-033 Package universal_reg_pkg SHALL hold the op encoding constants and the state typedef (IDLE, SHIFT).
REQ-034 One combinational sub-module, shift1_unit (parameter NBITS; inputs d, op, serial_in; outputs next_d, out_bit), SHALL implement REQ-024 and REQ-025; all flops SHALL reside in universal_reg.

Verification (NBITS=16, RESET_VALUE=0)
REQ-035 LOAD 0xA5C3 -> dataReg=0xA5C3 on the next cycle; done high for exactly 1 cycle; busy stays 0.
REQ-036 dataReg=0x00FF, SHL amt=4, serial_in=1 -> busy high 4 cycles; dataReg=0x0FFF with done; serial_out=0.
REQ-037 dataReg=0x8010, ASR amt=3 -> dataReg=0xF002 with done; serial_out=0.
REQ-038 dataReg=0x0001, ROR amt=1 -> dataReg=0x8000 and serial_out=1; a CLEAR start issued during busy is ignored.
REQ-039 SHL amt=0 -> dataReg unchanged and done on the next cycle.
REQ-040 rst low during a 10-step shift -> immediately dataReg=0, busy=0, serial_out=0; no done pulse.
